// File: rtl/sd_arb_pkg.sv
// Shared types and constants for the SD card request arbiter.
// Client slots: two floppy drives, then two ACSI targets.
package sd_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_RELEASE
    } arb_state_t;

    localparam int FDC_A = 0;
    localparam int FDC_B = 1;
    localparam int ACSI0 = 2;
    localparam int ACSI1 = 3;

    localparam int DEF_NUM_REQ = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IDX_W = idx_w(DEF_NUM_REQ);

endpackage

// File: rtl/sd_request_arbiter_rr_pick.sv
// Round-robin finder: first set request bit at or above the
// pointer, wrapping past the top slot back to slot 0.
module rr_pick
    import sd_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [idx_w(NUM_REQ)-1:0] i_ptr,
    output logic [idx_w(NUM_REQ)-1:0] o_idx,
    output logic                      o_found
);

    localparam int IW = idx_w(NUM_REQ);

    // Walk downward so the closest slot to the pointer is written last.
    always_comb begin
        int w_pos;
        o_idx   = '0;
        o_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            if (i_req[w_pos]) begin
                o_idx   = IW'(w_pos);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_request_arbiter.sv
// N-client SD image arbiter: round-robin grant, locked for a whole
// sector, with routed handshakes and a grant-to-busy watchdog.
module sd_request_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LBA_W   = 32,
    parameter int TIMEOUT = 1 << 20
) (
    input  logic                     clk_32,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_rd,
    input  logic [NUM_REQ-1:0]       req_wr,
    input  logic [NUM_REQ*LBA_W-1:0] req_lba,
    input  logic [NUM_REQ*8-1:0]     req_din,
    output logic [NUM_REQ-1:0]       client_busy,
    output logic [NUM_REQ-1:0]       client_done,
    output logic [NUM_REQ-1:0]       client_strobe,
    output logic [NUM_REQ-1:0]       sd_rd,
    output logic [NUM_REQ-1:0]       sd_wr,
    output logic [LBA_W-1:0]         sd_lba,
    output logic [7:0]               sd_din,
    input  logic                     sd_busy,
    input  logic                     sd_done,
    input  logic                     sd_dout_strobe,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     grant_valid,
    output logic                     timeout_err
);

    localparam int          IW      = idx_w(NUM_REQ);
    localparam bit          WD_EN   = (TIMEOUT != 0);
    localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

    arb_state_t          r_state;
    arb_state_t          w_state_nx;
    logic [IW-1:0]       r_idx;
    logic [IW-1:0]       r_rr;
    logic                r_rd;
    logic [31:0]         r_wdog;
    logic                r_terr;

    logic [IW-1:0]       w_pick;
    logic                w_found;
    logic                w_live;
    logic                w_wd_hit;
    logic                w_gv;
    logic                w_xfer_end;
    logic [NUM_REQ-1:0]  w_onehot;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req   (req_rd | req_wr),
        .i_ptr   (r_rr),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

    assign w_live     = r_rd ? req_rd[r_idx] : req_wr[r_idx];
    assign w_wd_hit   = WD_EN && (r_wdog == WD_LAST);
    assign w_xfer_end = sd_done || !sd_busy;
    assign w_gv       = (r_state == S_REQ) || (r_state == S_XFER);

    // Busy wins over a same-cycle drop or watchdog expiry.
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) w_state_nx = S_REQ;
            end
            S_REQ: begin
                if (sd_busy)       w_state_nx = S_XFER;
                else if (!w_live)  w_state_nx = S_IDLE;
                else if (w_wd_hit) w_state_nx = S_RELEASE;
            end
            S_XFER: begin
                if (w_xfer_end) w_state_nx = S_RELEASE;
            end
            S_RELEASE: w_state_nx = S_IDLE;
            default:   w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_32 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_rr    <= '0;
            r_rd    <= 1'b0;
            r_wdog  <= '0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_idx  <= w_pick;
                        r_rd   <= req_rd[w_pick];
                        r_wdog <= '0;
                    end
                end
                S_REQ: begin
                    r_wdog <= r_wdog + 32'd1;
                    if (!sd_busy && w_live && w_wd_hit) r_terr <= 1'b1;
                end
                S_XFER: begin
                    if (w_xfer_end) r_terr <= 1'b0;
                end
                S_RELEASE: begin
                    r_rr <= (int'(r_idx) == NUM_REQ - 1) ? '0 : r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_onehot        = '0;
        w_onehot[r_idx] = 1'b1;
        grant           = '0;
        sd_rd           = '0;
        sd_wr           = '0;
        client_busy     = '0;
        client_done     = '0;
        client_strobe   = '0;
        sd_lba          = '0;
        sd_din          = '0;
        if (w_gv) begin
            grant  = w_onehot;
            sd_lba = req_lba[int'(r_idx)*LBA_W +: LBA_W];
            sd_din = req_din[int'(r_idx)*8 +: 8];
            if (sd_busy)        client_busy   = w_onehot;
            if (sd_done)        client_done   = w_onehot;
            if (sd_dout_strobe) client_strobe = w_onehot;
        end
        if (r_state == S_REQ) begin
            if (r_rd && req_rd[r_idx])   sd_rd = w_onehot;
            if (!r_rd && req_wr[r_idx])  sd_wr = w_onehot;
        end
    end

    assign grant_valid = w_gv;
    assign timeout_err = r_terr;

endmodule
